pipelined_adder_nbit: RTL and testbench
=======================================

// Module: pipelined_adder_nbit
// PURPOSE
//  Parametrised N-bit add/subtract unit, successor to the 4-bit ripple adder.
//  Splits the carry chain into CHUNK-bit slices, one register stage per slice,
//  for timing closure at wide WIDTH.
//  Streaming valid/ready on both sides with backpressure. Adds subtract mode,
//  carry-in, and a signed-overflow flag.
//  Sits between operand sources and the datapath result bus.
// PARAMETERS
//  WIDTH   16  operand/sum width in bits; must be a multiple of CHUNK
//  CHUNK    4  bits resolved per pipeline stage
//  STAGES  (localparam) WIDTH/CHUNK = pipeline depth = latency in cycles
// PORTS
//  clk        in   1      single clock, rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operands present on a/b/sub/cin
//  in_ready   out  1      unit accepts operands this cycle
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  sub        in   1      0: a+b+cin; 1: a-b (a + ~b + 1, cin ignored)
//  cin        in   1      carry-in, add mode only
//  out_valid  out  1      result present
//  out_ready  in   1      consumer accepts result this cycle
//  sum        out  WIDTH  result, modulo 2^WIDTH
//  cout       out  1      carry-out of MSB; in subtract mode 1 = no borrow
//  ovf        out  1      two's-complement signed overflow
// BEHAVIOUR
//  - Reset (rst_n=0, async): all stage-valid bits, out_valid, sum, cout and
//    ovf are cleared to 0. In-flight operations are discarded and never emitted.
//  - Global advance: adv = !out_valid | out_ready. in_ready = adv.
//    All stages shift only when adv=1. Bubbles are not collapsed.
//  - Transfer occurs when in_valid & in_ready, or when out_valid & out_ready.
//  - Latency: a result is visible exactly STAGES cycles after acceptance when
//    there is no stall. Results keep strict FIFO order.
//    Full throughput is 1 result per cycle.
//  - Stage 0 captures a, b' = b ^ {WIDTH{sub}}, and c0 = sub ? 1 : cin.
//    It resolves chunk 0 and registers that partial sum and its carry.
//  - Stage k resolves chunk k using the carry registered by stage k-1.
//    Unresolved upper operand chunks are skewed forward unchanged, and
//    resolved lower sum chunks are carried forward unchanged.
//  - Final stage drives sum, cout = carry out of chunk STAGES-1, and
//    ovf = (a[W-1] == b'[W-1]) & (sum[W-1] != a[W-1]).
//  - Stall: while out_valid=1 and out_ready=0, all stage registers and
//    outputs hold stable and in_ready=0. in_valid/data seen in that
//    cycle are not consumed.
//  - Simultaneous pop and push in the same cycle: both occur and the
//    pipeline shifts by one.
//  - Operands with in_valid=0 enter as bubbles. Their stage-valid bit is 0
//    and their data is don't-care.
//  - STAGES=1 (CHUNK=WIDTH) degenerates to a single registered adder with
//    latency 1.
// STRUCTURE
//  - Shared package adder_pkg holds:
//      OP_ADD=1'b0 and OP_SUB=1'b1 constants;
//      a function asserting WIDTH % CHUNK == 0, used in an elaboration check.
//  - Sub-module carry_chunk_adder: combinational CHUNK-bit adder
//    (x, y, ci -> s, co). It is instantiated once per stage by a generate
//    loop. The top holds only the skew/valid registers and the handshake.
// TESTING  (WIDTH=16, CHUNK=4, latency 4)
//  1. a=0x0000 b=0x0001 sub=0 cin=0 -> 4 cycles later sum=0x0001 cout=0 ovf=0.
//  2. a=0xFFFF b=0x0001 sub=0 -> sum=0x0000 cout=1 ovf=0
//     (carry ripples through all 4 stages).
//  3. a=0x7FFF b=0x0001 sub=0 -> sum=0x8000 cout=0 ovf=1;
//     a=0x00FF b=0x0000 cin=1 -> sum=0x0100.
//  4. a=0x0005 b=0x0007 sub=1 -> sum=0xFFFE cout=0 ovf=0;
//     a=0x8000 b=0x0001 sub=1 -> sum=0x7FFF ovf=1.
//  5. Stream 8 back-to-back ops, with out_ready=0 in cycles 5-8
//     -> in_ready=0 in those cycles, all 8 results arrive in order,
//     none dropped or duplicated, outputs stable while stalled.
//  6. Accept 3 ops, then pulse rst_n low mid-cycle -> out_valid=0
//     immediately; no result emitted after release; the next op
//     completes with latency 4.
//  All scenarios are checked against a behavioural model (a + (b^sub) + c0)
//  in a scoreboard, plus 1000 random ops with random out_ready.

Source files
------------

// File: rtl/pipelined_adder_nbit_pkg.sv
// ---------------------------------------------------------------------------
// adder_pkg
// Shared definitions for the pipelined N-bit add/subtract unit.
//   OP_ADD / OP_SUB : encodings of the 'sub' operand-mode bit
//   chunk_ok()      : parameter legality test used at elaboration
// ---------------------------------------------------------------------------
package adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // True when the operand width splits into a whole number of chunks.
  function automatic bit chunk_ok(input int unsigned width, input int unsigned chunk);
    return (chunk != 32'd0) && (width != 32'd0) && ((width % chunk) == 32'd0);
  endfunction

endpackage

// File: rtl/pipelined_adder_nbit_if.sv
// ---------------------------------------------------------------------------
// pipelined_adder_nbit_if
// Streaming operand/result bundle of the pipelined adder.
//   in_valid/in_ready   : operand handshake (a, b, sub, cin)
//   out_valid/out_ready : result handshake (sum, cout, ovf)
// Modports:
//   master : operand source + result consumer
//   slave  : the adder itself
// ---------------------------------------------------------------------------
interface pipelined_adder_nbit_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, sub, cin, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, sub, cin, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_adder_nbit_carry_chunk_adder.sv
// ---------------------------------------------------------------------------
// carry_chunk_adder
// Combinational W-bit adder slice: {co, s} = x + y + ci.
// Ports:
//   x, y : W-bit operand slices
//   ci   : carry into the slice
//   s    : W-bit slice sum
//   co   : carry out of the slice MSB
// ---------------------------------------------------------------------------
module carry_chunk_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co
);

  assign {co, s} = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};

endmodule

// File: rtl/pipelined_adder_nbit.sv
// ---------------------------------------------------------------------------
// pipelined_adder_nbit
// N-bit add/subtract unit whose carry chain is cut into CHUNK-bit slices,
// one register stage per slice (latency = STAGES = WIDTH/CHUNK cycles).
// Streaming valid/ready on both sides; the whole pipe advances together.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of pipelined_adder_nbit_if
//           (in_valid/in_ready/a/b/sub/cin, out_valid/out_ready/sum/cout/ovf)
// ---------------------------------------------------------------------------
module pipelined_adder_nbit
  import adder_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  pipelined_adder_nbit_if.slave bus
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int LAST   = STAGES - 1;

  if (!chunk_ok(WIDTH, CHUNK)) begin : g_cfg_check
    $fatal(1, "pipelined_adder_nbit: WIDTH must be a non-zero multiple of CHUNK");
  end

  // Stage registers. a_r/b_r carry the (skewed) operands forward so upper
  // chunks are still available when their stage is reached; s_r holds the
  // sum chunks resolved so far; c_r is the carry out of the stage's chunk.
  logic [WIDTH-1:0] a_r [STAGES];
  logic [WIDTH-1:0] b_r [STAGES];
  logic [WIDTH-1:0] s_r [STAGES];
  logic             c_r [STAGES];
  logic             v_r [STAGES];
  logic             ovf_r;

  // Inputs seen by each stage this cycle (bus for stage 0, previous stage otherwise).
  logic [WIDTH-1:0] src_a_s [STAGES];
  logic [WIDTH-1:0] src_b_s [STAGES];
  logic [WIDTH-1:0] src_s_s [STAGES];
  logic             src_c_s [STAGES];
  logic             src_v_s [STAGES];
  logic [WIDTH-1:0] nxt_s_s [STAGES];
  logic [CHUNK-1:0] chunk_s_s [STAGES];
  logic             chunk_co_s [STAGES];
  logic             adv_s;

  // Bubbles are not collapsed: the pipe moves only as a whole.
  assign adv_s         = ~v_r[LAST] | bus.out_ready;
  assign bus.in_ready  = adv_s;
  assign bus.out_valid = v_r[LAST];
  assign bus.sum       = s_r[LAST];
  assign bus.cout      = c_r[LAST];
  assign bus.ovf       = ovf_r;

  // Select the operands/carry feeding each stage; subtract is a + ~b + 1.
  always_comb begin
    src_a_s[0] = bus.a;
    src_s_s[0] = {WIDTH{1'b0}};
    src_v_s[0] = bus.in_valid;
    case (bus.sub)
      OP_ADD: begin
        src_b_s[0] = bus.b;
        src_c_s[0] = bus.cin;
      end
      OP_SUB: begin
        src_b_s[0] = ~bus.b;
        src_c_s[0] = 1'b1;
      end
      default: begin
        src_b_s[0] = bus.b;
        src_c_s[0] = bus.cin;
      end
    endcase
    for (int k = 1; k < STAGES; k++) begin
      src_a_s[k] = a_r[k-1];
      src_b_s[k] = b_r[k-1];
      src_s_s[k] = s_r[k-1];
      src_c_s[k] = c_r[k-1];
      src_v_s[k] = v_r[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_chunk
    carry_chunk_adder #(
      .W (CHUNK)
    ) u_add (
      .x  (src_a_s[k][k*CHUNK +: CHUNK]),
      .y  (src_b_s[k][k*CHUNK +: CHUNK]),
      .ci (src_c_s[k]),
      .s  (chunk_s_s[k]),
      .co (chunk_co_s[k])
    );
  end

  // Splice each stage's freshly resolved chunk into the partial sum.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      nxt_s_s[k]                  = src_s_s[k];
      nxt_s_s[k][k*CHUNK +: CHUNK] = chunk_s_s[k];
    end
  end

  // Pipeline registers: shift all stages together on advance, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v_r[k] <= 1'b0;
        a_r[k] <= {WIDTH{1'b0}};
        b_r[k] <= {WIDTH{1'b0}};
        s_r[k] <= {WIDTH{1'b0}};
        c_r[k] <= 1'b0;
      end
      ovf_r <= 1'b0;
    end else if (adv_s) begin
      for (int k = 0; k < STAGES; k++) begin
        v_r[k] <= src_v_s[k];
        a_r[k] <= src_a_s[k];
        b_r[k] <= src_b_s[k];
        s_r[k] <= nxt_s_s[k];
        c_r[k] <= chunk_co_s[k];
      end
      // Overflow: operands (after inversion) agree in sign but the sum does not.
      ovf_r <= (src_a_s[LAST][WIDTH-1] == src_b_s[LAST][WIDTH-1]) &
               (nxt_s_s[LAST][WIDTH-1] != src_a_s[LAST][WIDTH-1]);
    end
  end

endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// ---------------------------------------------------------------------------
// tb_pipelined_adder_nbit
// Directed and random stimulus for pipelined_adder_nbit (WIDTH=16, CHUNK=4)
// with an arithmetic reference model and an in-order scoreboard.
// ---------------------------------------------------------------------------
module tb_pipelined_adder_nbit;

  localparam int W   = 16;
  localparam int C   = 4;
  localparam int LAT = 4;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_adder_nbit_if #(.WIDTH(W)) bus ();

  pipelined_adder_nbit #(
    .WIDTH (W),
    .CHUNK (C)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int   checks = 0;
  int   errors = 0;
  int   pops = 0;
  int   cyc = 0;
  int   rdy_mode = 0;
  int   s5_base = 0;
  int   stall_cnt = 0;
  res_t exp_q[$];
  logic prev_stall = 1'b0;
  logic [18:0] snap = 19'd0;

  // Reference: plain integer arithmetic, signed range test for overflow.
  function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                 input logic sub, input logic cin);
    res_t r;
    int ua, ub, sa, sb, ur, sr;
    ua = int'(a);
    ub = int'(b);
    sa = int'($signed(a));
    sb = int'($signed(b));
    if (sub) begin
      ur = ua - ub;
      sr = sa - sb;
      r.cout = (ua >= ub);
    end else begin
      ur = ua + ub + int'(cin);
      sr = sa + sb + int'(cin);
      r.cout = (ur > 65535);
    end
    r.sum = ur[15:0];
    r.ovf = (sr > 32767) || (sr < -32768);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Result-side ready pattern, changed just after each rising edge.
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = !(((cyc - s5_base) >= 5) && ((cyc - s5_base) <= 8));
        2: bus.out_ready = 1'($urandom_range(0, 1));
        3: bus.out_ready = 1'b0;
        default: bus.out_ready = 1'b1;
      endcase
    end
  end

  // Reset discards everything in flight.
  initial forever begin
    @(negedge rst_n);
    exp_q.delete();
    prev_stall = 1'b0;
  end

  // Scoreboard: decide each cycle's transfers midway between rising edges.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      res_t e;
      chk("in_ready_rule", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
      if (prev_stall)
        chk("stall_hold", 32'({bus.out_valid, bus.sum, bus.cout, bus.ovf}), 32'(snap));
      if (rdy_mode == 1 && bus.out_valid && !bus.out_ready) stall_cnt++;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out", 32'(bus.out_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_sum", 32'(bus.sum), 32'(e.sum));
          chk("sb_cout", 32'(bus.cout), 32'(e.cout));
          chk("sb_ovf", 32'(bus.ovf), 32'(e.ovf));
          pops++;
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.a, bus.b, bus.sub, bus.cin));
      prev_stall = bus.out_valid && !bus.out_ready;
      snap = {bus.out_valid, bus.sum, bus.cout, bus.ovf};
    end
  end

  // Present one operand set until accepted; called just after a rising edge.
  task automatic send(input logic [15:0] a, input logic [15:0] b,
                      input logic sub, input logic cin);
    int   guard;
    logic acc;
    guard = 0;
    acc = 1'b0;
    bus.a = a;
    bus.b = b;
    bus.sub = sub;
    bus.cin = cin;
    bus.in_valid = 1'b1;
    while (!acc && guard < 500) begin
      @(negedge clk);
      acc = bus.in_ready && rst_n;
      @(posedge clk);
      #1;
      guard++;
    end
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b0;
  endtask

  // Single op into an empty pipe: exact latency plus literal expectations.
  task automatic directed(input string name, input logic [15:0] a, input logic [15:0] b,
                          input logic sub, input logic cin, input logic [15:0] es,
                          input logic ec, input logic eo);
    res_t m;
    m = model(a, b, sub, cin);
    chk({name, "_model"}, 32'(m), 32'({es, ec, eo}));
    send(a, b, sub, cin);
    for (int k = 1; k <= LAT; k++) begin
      @(negedge clk);
      if (k < LAT) begin
        chk({name, "_early"}, 32'(bus.out_valid), 32'd0);
      end else begin
        chk({name, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({name, "_sum"}, 32'(bus.sum), 32'(es));
        chk({name, "_cout"}, 32'(bus.cout), 32'(ec));
        chk({name, "_ovf"}, 32'(bus.ovf), 32'(eo));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int budget);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && g < budget) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk(name, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int p0;
    int g;
    bus.in_valid = 1'b0;
    bus.a = 16'h0000;
    bus.b = 16'h0000;
    bus.sub = 1'b0;
    bus.cin = 1'b0;
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    directed("t1_inc",     16'h0000, 16'h0001, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b0);
    directed("t2_ripple",  16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed("t3_posovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed("t3_cin",     16'h00FF, 16'h0000, 1'b0, 1'b1, 16'h0100, 1'b0, 1'b0);
    directed("t4_sub",     16'h0005, 16'h0007, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    directed("t4_subovf",  16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Eight back-to-back ops with the consumer stalling in cycles 5-8.
    p0 = pops;
    stall_cnt = 0;
    s5_base = cyc + 1;
    rdy_mode = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++)
      send(16'(16'h1357 * i + 16'h00F0), 16'(16'h0F0F ^ (16'h1111 * i)), 1'(i % 2), 1'(i % 3 == 0));
    drain("t5_drain", 100);
    chk("t5_count", 32'(pops - p0), 32'd8);
    chk("t5_stalls", 32'(stall_cnt), 32'd4);
    rdy_mode = 0;

    // Three ops in flight, reset mid-cycle, nothing may emerge afterwards.
    rdy_mode = 3;
    @(posedge clk);
    #1;
    send(16'h1111, 16'h2222, 1'b0, 1'b0);
    send(16'h3333, 16'h4444, 1'b0, 1'b1);
    send(16'h5555, 16'h0001, 1'b1, 1'b0);
    g = 0;
    while (!bus.out_valid && g < 20) begin
      @(posedge clk);
      #1;
      g++;
    end
    chk("t6_before_rst", 32'(bus.out_valid), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("t6_rst_sum", 32'(bus.sum), 32'd0);
    chk("t6_rst_cout", 32'(bus.cout), 32'd0);
    #1;
    rst_n = 1'b1;
    rdy_mode = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t6_no_ghost", 32'(bus.out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    directed("t6_after", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

    // Random operands with random consumer backpressure and input gaps.
    rdy_mode = 2;
    for (int i = 0; i < 1000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    rdy_mode = 0;
    drain("rand_drain", 300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
